// File: rtl/ram_pkg.sv
// ----------------------------------------------------------------------------
// ram_pkg
// Shared definitions for the ram_sync block:
//   - clear-sequencer state encoding (CLEAR, RUN)
//   - response flag bundle carried from the request edge to the response cycle
//   - byte_merge(): combine an old word and a new word under a byte mask
//   - offset_bits(): number of byte-offset bits in a byte address
// ----------------------------------------------------------------------------
package ram_pkg;

  // FSM encoding kept as plain constants so older tools and netlists that
  // expect a raw bit vector can still read the state register directly.
  localparam int STATE_W = 1;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_CLEAR = 1'b0;
  localparam state_t ST_RUN   = 1'b1;

  // Flags that travel with each accepted request into the response cycle.
  typedef struct packed {
    logic vld;  // request accepted at the previous edge
    logic err;  // word index was out of range
  } rsp_flags_t;

  // byte_merge works on a fixed maximum width so a single package function
  // serves every DATA_WIDTH instance; callers zero-extend their operands
  // and truncate the result back to their own width.
  localparam int MERGE_MAX_W = 1024;
  localparam int MERGE_MAX_B = MERGE_MAX_W / 8;

  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0] old_word,
    input logic [MERGE_MAX_W-1:0] new_word,
    input logic [MERGE_MAX_B-1:0] mask
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_word;
    for (int b = 0; b < MERGE_MAX_B; b++) begin
      if (mask[b]) begin
        res[b*8 +: 8] = new_word[b*8 +: 8];
      end
    end
    return res;
  endfunction

  // Number of low address bits that select a byte inside a word.
  function automatic int offset_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// ----------------------------------------------------------------------------
// ram_clear_ctrl
// Clear sequencer for ram_sync. After reset it walks a counter over word
// indices 0..DEPTH-1, requesting one zero write per cycle, then settles in
// RUN and raises ready. With CLEAR_ON_RESET = 0 it starts in RUN and ready
// rises on the first clock edge after reset is released.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   ready    out  1 = RUN state, block accepts requests
//   clr_we   out  1 = write zero to word clr_idx this cycle
//   clr_idx  out  word index being cleared
// ----------------------------------------------------------------------------
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int DEPTH          = 1024,
  parameter int CLEAR_ON_RESET = 1,
  parameter int CNT_W          = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ready,
  output logic             clr_we,
  output logic [CNT_W-1:0] clr_idx
);

  localparam state_t           RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
  localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // RUN is terminal until the next reset.
      end
    endcase
    // ready is registered off the next state so that it is low throughout
    // reset and rises on the very edge that completes the last clear write.
    ready_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign ready   = ready_q;
  assign clr_idx = cnt_q;

endmodule

// File: rtl/ram_sync.sv
// ----------------------------------------------------------------------------
// ram_sync
// Two-port synchronous RAM with byte-addressed ports.
//   Port 1: read only.
//   Port 2: read or byte-masked write; a write returns the merged new word
//           (write-through).
// Both ports have a one-cycle latency and accept a request every cycle.
// A port-1 read of the word port 2 writes in the same cycle returns the new
// word. Word indices >= DEPTH respond with data 0 and err = 1 and never
// write. An optional clear pass zeroes the array after reset; requests are
// ignored until ready is high.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   ready             1 = requests accepted
//   req1, a1          port-1 read request, byte address
//   do1, vld1, err1   port-1 data, valid pulse, out-of-range flag
//   req2, we2, a2     port-2 request, write enable, byte address
//   di2, m2           port-2 write data, byte-write mask
//   do2, vld2, err2   port-2 data, valid pulse, out-of-range flag
// ----------------------------------------------------------------------------
module ram_sync
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 1024,
  parameter int ADDR_WIDTH     = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    ready,
  input  logic                    req1,
  input  logic [ADDR_WIDTH-1:0]   a1,
  output logic [DATA_WIDTH-1:0]   do1,
  output logic                    vld1,
  output logic                    err1,
  input  logic                    req2,
  input  logic                    we2,
  input  logic [ADDR_WIDTH-1:0]   a2,
  input  logic [DATA_WIDTH-1:0]   di2,
  input  logic [DATA_WIDTH/8-1:0] m2,
  output logic [DATA_WIDTH-1:0]   do2,
  output logic                    vld2,
  output logic                    err2
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int OFF_W  = offset_bits(DATA_WIDTH);
  localparam int IDX_W  = ADDR_WIDTH - OFF_W;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // DEPTH widened by one bit so the range compare never truncates.
  localparam logic [IDX_W:0] DEPTH_X = (IDX_W + 1)'(DEPTH);

  // --------------------------------------------------------------------------
  // Address decode and request acceptance
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0]  idx1, idx2;
  logic [MEM_AW-1:0] ra1, ra2;
  logic              oor1, oor2;
  logic              acc1, acc2;
  logic              wr2;

  assign idx1 = a1[ADDR_WIDTH-1:OFF_W];
  assign idx2 = a2[ADDR_WIDTH-1:OFF_W];
  assign ra1  = idx1[MEM_AW-1:0];
  assign ra2  = idx2[MEM_AW-1:0];
  assign oor1 = ({1'b0, idx1} >= DEPTH_X);
  assign oor2 = ({1'b0, idx2} >= DEPTH_X);

  assign acc1 = ready & req1;
  assign acc2 = ready & req2;
  assign wr2  = acc2 & we2 & ~oor2;

  // Byte-offset bits only select a byte within a word, which this RAM
  // does not need; fold them into a sink so they are visibly consumed.
  generate
    if (OFF_W > 0) begin : g_off_sink
      logic unused_offset_bits;
      assign unused_offset_bits = ^{a1[OFF_W-1:0], a2[OFF_W-1:0]};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Clear sequencer
  // --------------------------------------------------------------------------
  logic              clr_we;
  logic [MEM_AW-1:0] clr_idx;

  ram_clear_ctrl #(
    .DEPTH         (DEPTH),
    .CLEAR_ON_RESET(CLEAR_ON_RESET),
    .CNT_W         (MEM_AW)
  ) u_clear_ctrl (
    .clk    (clk),
    .rst_n  (rst_n),
    .ready  (ready),
    .clr_we (clr_we),
    .clr_idx(clr_idx)
  );

  // --------------------------------------------------------------------------
  // Write port mux: the clear pass and port 2 share the array's write port.
  // They never collide because port 2 is only accepted once ready is high.
  // --------------------------------------------------------------------------
  logic                  wr_en;
  logic [MEM_AW-1:0]     wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NB-1:0]         wr_mask;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = ra2;
    wr_data = di2;
    wr_mask = m2;
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_addr = clr_idx;
      wr_data = '0;
      wr_mask = '1;
    end else if (wr2) begin
      wr_en = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Storage: byte-enabled write, registered reads. Port 2 reads the old
  // word at the same edge it writes; that old word is what the response
  // cycle merges with the captured write data.
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd1_q, rd2_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (wr_en && wr_mask[b]) begin
        mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
    if (acc1) begin
      rd1_q <= mem[ra1];
    end
    if (acc2) begin
      rd2_q <= mem[ra2];
    end
  end

  // --------------------------------------------------------------------------
  // Request-to-response pipeline
  // --------------------------------------------------------------------------
  rsp_flags_t            p1_q, p1_d;
  rsp_flags_t            p2_q, p2_d;
  logic                  we2_q, we2_d;
  logic                  fwd1_q, fwd1_d;
  logic [DATA_WIDTH-1:0] di2_q, di2_d;
  logic [NB-1:0]         m2_q, m2_d;
  logic [DATA_WIDTH-1:0] do1_hold_q, do1_hold_d;
  logic [DATA_WIDTH-1:0] do2_hold_q, do2_hold_d;

  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] do1_new, do2_new;

  always_comb begin
    p1_d.vld = acc1;
    p1_d.err = acc1 & oor1;
    p2_d.vld = acc2;
    p2_d.err = acc2 & oor2;
    we2_d    = acc2 & we2;
    // Port 1 hits the word port 2 is writing right now: the array read
    // returns the old word, so the response must use the merged word.
    fwd1_d   = acc1 & wr2 & (idx1 == idx2);
    di2_d    = di2;
    m2_d     = m2;
  end

  always_comb begin
    merged = DATA_WIDTH'(byte_merge(MERGE_MAX_W'(rd2_q), MERGE_MAX_W'(di2_q),
                                    MERGE_MAX_B'(m2_q)));

    do2_new = rd2_q;
    if (p2_q.err) begin
      do2_new = '0;
    end else if (we2_q) begin
      do2_new = merged;
    end

    do1_new = rd1_q;
    if (p1_q.err) begin
      do1_new = '0;
    end else if (fwd1_q) begin
      do1_new = merged;
    end

    // Outputs present new data during the valid cycle and otherwise hold
    // whatever they last showed.
    do1_hold_d = p1_q.vld ? do1_new : do1_hold_q;
    do2_hold_d = p2_q.vld ? do2_new : do2_hold_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_q       <= '0;
      p2_q       <= '0;
      we2_q      <= 1'b0;
      fwd1_q     <= 1'b0;
      di2_q      <= '0;
      m2_q       <= '0;
      do1_hold_q <= '0;
      do2_hold_q <= '0;
    end else begin
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      we2_q      <= we2_d;
      fwd1_q     <= fwd1_d;
      di2_q      <= di2_d;
      m2_q       <= m2_d;
      do1_hold_q <= do1_hold_d;
      do2_hold_q <= do2_hold_d;
    end
  end

  assign do1  = do1_hold_d;
  assign vld1 = p1_q.vld;
  assign err1 = p1_q.vld & p1_q.err;
  assign do2  = do2_hold_d;
  assign vld2 = p2_q.vld;
  assign err2 = p2_q.vld & p2_q.err;

endmodule

// File: tb/tb_ram_sync.sv
// ----------------------------------------------------------------------------
// tb_ram_sync
// Directed bench for ram_sync: a 32-bit, 16-word instance with clearing
// enabled, plus a 64-bit, 16-word instance for wide byte-mask writes.
// ----------------------------------------------------------------------------
module tb_ram_sync;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // 32-bit instance
  logic        ready;
  logic        req1 = 1'b0;
  logic [31:0] a1 = '0;
  logic [31:0] do1;
  logic        vld1, err1;
  logic        req2 = 1'b0;
  logic        we2 = 1'b0;
  logic [31:0] a2 = '0;
  logic [31:0] di2 = '0;
  logic [3:0]  m2 = '0;
  logic [31:0] do2;
  logic        vld2, err2;

  ram_sync #(
    .DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(32), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready),
    .req1(req1), .a1(a1), .do1(do1), .vld1(vld1), .err1(err1),
    .req2(req2), .we2(we2), .a2(a2), .di2(di2), .m2(m2),
    .do2(do2), .vld2(vld2), .err2(err2)
  );

  // 64-bit instance
  logic        ready_w;
  logic        req1_w = 1'b0;
  logic [31:0] a1_w = '0;
  logic [63:0] do1_w;
  logic        vld1_w, err1_w;
  logic        req2_w = 1'b0;
  logic        we2_w = 1'b0;
  logic [31:0] a2_w = '0;
  logic [63:0] di2_w = '0;
  logic [7:0]  m2_w = '0;
  logic [63:0] do2_w;
  logic        vld2_w, err2_w;

  ram_sync #(
    .DATA_WIDTH(64), .DEPTH(16), .ADDR_WIDTH(32), .CLEAR_ON_RESET(1)
  ) dut_w (
    .clk(clk), .rst_n(rst_n), .ready(ready_w),
    .req1(req1_w), .a1(a1_w), .do1(do1_w), .vld1(vld1_w), .err1(err1_w),
    .req2(req2_w), .we2(we2_w), .a2(a2_w), .di2(di2_w), .m2(m2_w),
    .do2(do2_w), .vld2(vld2_w), .err2(err2_w)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles until ready rises, with requests held on both ports the
  // whole time; none of them may produce a valid pulse.
  task automatic wait_ready(output int cycles);
    cycles = 40;
    req1 = 1'b1; a1 = 32'h8;
    req2 = 1'b1; we2 = 1'b1; a2 = 32'h8; di2 = 32'hFFFF_FFFF; m2 = 4'hF;
    for (int i = 1; i <= 40; i++) begin
      tick();
      check("no_vld1_while_clearing", {63'd0, vld1}, 64'd0);
      check("no_vld2_while_clearing", {63'd0, vld2}, 64'd0);
      if (ready) begin
        cycles = i;
        break;
      end
    end
    req1 = 1'b0; req2 = 1'b0; we2 = 1'b0;
  endtask

  task automatic rd1(input logic [31:0] addr, input logic [31:0] exp);
    req1 = 1'b1; a1 = addr;
    tick();
    req1 = 1'b0;
    $display("txn rd1 a=%h do1=%h vld1=%b err1=%b", addr, do1, vld1, err1);
    check("rd1_vld", {63'd0, vld1}, 64'd1);
    check("rd1_err", {63'd0, err1}, 64'd0);
    check("rd1_data", {32'd0, do1}, {32'd0, exp});
  endtask

  task automatic wr2(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask,
                     input logic [31:0] exp, input logic exp_err);
    req2 = 1'b1; we2 = 1'b1; a2 = addr; di2 = data; m2 = mask;
    tick();
    req2 = 1'b0; we2 = 1'b0;
    $display("txn wr2 a=%h di=%h m=%h do2=%h vld2=%b err2=%b", addr, data, mask, do2, vld2, err2);
    check("wr2_vld", {63'd0, vld2}, 64'd1);
    check("wr2_err", {63'd0, err2}, {63'd0, exp_err});
    check("wr2_data", {32'd0, do2}, {32'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;

    // Reset state
    repeat (3) tick();
    $display("txn reset ready=%b vld1=%b vld2=%b do1=%h do2=%h", ready, vld1, vld2, do1, do2);
    check("rst_ready", {63'd0, ready}, 64'd0);
    check("rst_vld1", {63'd0, vld1}, 64'd0);
    check("rst_vld2", {63'd0, vld2}, 64'd0);
    check("rst_do1", {32'd0, do1}, 64'd0);
    check("rst_do2", {32'd0, do2}, 64'd0);

    // Start clearing, abort at clear count 7, restart from zero
    rst_n = 1'b1;
    repeat (7) tick();
    check("ready_low_mid_clear", {63'd0, ready}, 64'd0);
    rst_n = 1'b0;
    #1;
    $display("txn reset_mid_clear ready=%b", ready);
    check("ready_in_reset", {63'd0, ready}, 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    wait_ready(cycles);
    $display("txn wait_ready cycles=%0d", cycles);
    check("ready_after_16", cycles, 64'd16);
    check("ready_w_after_16", {63'd0, ready_w}, 64'd1);

    // Cleared words; the blocked write to 0x8 must not have landed
    rd1(32'h3C, 32'h0);
    rd1(32'h8, 32'h0);

    // Byte-masked write merge
    wr2(32'h8, 32'hAABB_CCDD, 4'hF, 32'hAABB_CCDD, 1'b0);
    wr2(32'h8, 32'h1122_3344, 4'h5, 32'hAA22_CC44, 1'b0);
    rd1(32'h8, 32'hAA22_CC44);

    // Idle cycle: no pulse, data held
    tick();
    check("idle_vld1", {63'd0, vld1}, 64'd0);
    check("idle_hold_do1", {32'd0, do1}, 64'hAA22_CC44);

    // Low byte-offset bits ignored
    rd1(32'hB, 32'hAA22_CC44);

    // Same-cycle write and read of one word: write-first forwarding
    req1 = 1'b1; a1 = 32'h10;
    req2 = 1'b1; we2 = 1'b1; a2 = 32'h10; di2 = 32'hDEAD_BEEF; m2 = 4'hF;
    tick();
    req1 = 1'b0; req2 = 1'b0; we2 = 1'b0;
    $display("txn fwd do1=%h vld1=%b do2=%h vld2=%b", do1, vld1, do2, vld2);
    check("fwd_vld1", {63'd0, vld1}, 64'd1);
    check("fwd_do1", {32'd0, do1}, 64'hDEAD_BEEF);
    check("fwd_do2", {32'd0, do2}, 64'hDEAD_BEEF);

    // Out-of-range write: index 16 aliases index 0 in the low bits
    wr2(32'h40, 32'h1234_5678, 4'hF, 32'h0, 1'b1);
    rd1(32'h0, 32'h0);
    rd1(32'h3C, 32'h0);
    rd1(32'h10, 32'hDEAD_BEEF);

    // Out-of-range read on port 1
    req1 = 1'b1; a1 = 32'h44;
    tick();
    req1 = 1'b0;
    $display("txn rd1_oor do1=%h vld1=%b err1=%b", do1, vld1, err1);
    check("oor1_vld", {63'd0, vld1}, 64'd1);
    check("oor1_err", {63'd0, err1}, 64'd1);
    check("oor1_data", {32'd0, do1}, 64'd0);

    // Both ports read the same word
    req1 = 1'b1; a1 = 32'h8;
    req2 = 1'b1; we2 = 1'b0; a2 = 32'h8;
    tick();
    req1 = 1'b0; req2 = 1'b0;
    $display("txn dual_rd do1=%h do2=%h", do1, do2);
    check("dual_rd_do1", {32'd0, do1}, 64'hAA22_CC44);
    check("dual_rd_do2", {32'd0, do2}, 64'hAA22_CC44);
    check("dual_rd_err2", {63'd0, err2}, 64'd0);

    // Write with empty mask: no-op that still reports the stored word
    wr2(32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

    // Back-to-back traffic on both ports
    req2 = 1'b1; we2 = 1'b1; a2 = 32'h14; di2 = 32'h0101_0101; m2 = 4'hF;
    req1 = 1'b1; a1 = 32'h18;
    tick();
    $display("txn b2b_0 do1=%h do2=%h", do1, do2);
    check("b2b0_vld2", {63'd0, vld2}, 64'd1);
    check("b2b0_do2", {32'd0, do2}, 64'h0101_0101);
    check("b2b0_do1", {32'd0, do1}, 64'h0);
    a2 = 32'h18; di2 = 32'h0202_0202; a1 = 32'h14;
    tick();
    $display("txn b2b_1 do1=%h do2=%h", do1, do2);
    check("b2b1_vld1", {63'd0, vld1}, 64'd1);
    check("b2b1_do2", {32'd0, do2}, 64'h0202_0202);
    check("b2b1_do1", {32'd0, do1}, 64'h0101_0101);
    we2 = 1'b0; a1 = 32'h18;
    tick();
    req1 = 1'b0; req2 = 1'b0;
    $display("txn b2b_2 do1=%h do2=%h", do1, do2);
    check("b2b2_vld2", {63'd0, vld2}, 64'd1);
    check("b2b2_do1", {32'd0, do1}, 64'h0202_0202);
    check("b2b2_do2", {32'd0, do2}, 64'h0202_0202);

    // 64-bit instance: mask 0x81 touches only bytes 0 and 7
    req2_w = 1'b1; we2_w = 1'b1; a2_w = 32'h0; di2_w = 64'h1111_1111_1111_1111; m2_w = 8'hFF;
    tick();
    $display("txn w64_full do2=%h", do2_w);
    check("w64_full", do2_w, 64'h1111_1111_1111_1111);
    di2_w = 64'hAAAA_AAAA_AAAA_AAAA; m2_w = 8'h81;
    tick();
    req2_w = 1'b0; we2_w = 1'b0;
    $display("txn w64_mask81 do2=%h", do2_w);
    check("w64_mask81", do2_w, 64'hAA11_1111_1111_11AA);
    req1_w = 1'b1; a1_w = 32'h7;
    tick();
    req1_w = 1'b0;
    $display("txn w64_rd do1=%h vld1=%b", do1_w, vld1_w);
    check("w64_rd_vld", {63'd0, vld1_w}, 64'd1);
    check("w64_rd", do1_w, 64'hAA11_1111_1111_11AA);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
